// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative multiply/divide sequencer for the multicycle MIPS core.
// Executes mult, multu, div and divu one bit per cycle and holds the 64-bit result in HI/LO.
// Optional build macro: MULT_DIV_EARLY_EXIT_EN. When it is defined, a multiply leaves RUN
// as soon as no set multiplier bits remain to be processed.
module mult_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

    // Two's-complement negation, WIDTH bits.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Two's-complement negation, 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] f_neg_wide(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    // Magnitude of x when treated as signed; unchanged when signed_en is low.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic signed_en);
        logic [WIDTH-1:0] m;
        if (signed_en && x[WIDTH-1]) begin
            m = f_neg(x);
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t               state_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     opa_r;      // multiplicand, then dividend / quotient shifter
    logic [WIDTH-1:0]     opb_r;      // multiplier shifter, or divisor
    logic [2*WIDTH-1:0]   mcand_r;    // multiplicand aligned to the current multiplier bit
    logic [2*WIDTH-1:0]   acc_r;      // product accumulator
    logic [WIDTH:0]       rem_r;      // partial remainder
    logic [CNT_W-1:0]     cnt_r;
    logic                 sign_a_r;
    logic                 sign_b_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 div_zero_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_div_s;
    logic                 is_signed_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [2*WIDTH-1:0]   mul_sum_s;
    logic [WIDTH+1:0]     div_trial_s;
    logic                 div_ge_s;
    logic [WIDTH:0]       div_next_rem_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
`ifdef MULT_DIV_EARLY_EXIT_EN
    logic                 mul_last_s;
`endif

    // Datapath: operand magnitudes, shift-add step, restoring-division trial and sign fix-up.
    always_comb begin
        is_div_s    = op_r[1];
        is_signed_s = ~op_r[0];
        mag_a_s     = f_mag(opa_r, is_signed_s);
        mag_b_s     = f_mag(opb_r, is_signed_s);
        mul_sum_s   = acc_r + mcand_r;
        // Shift the next dividend bit into the remainder and try subtracting the divisor;
        // the extra top bit of the trial is the borrow.
        div_trial_s = {rem_r, opa_r[WIDTH-1]} - {2'b00, opb_r};
        div_ge_s    = ~div_trial_s[WIDTH+1];
        if (div_ge_s) begin
            div_next_rem_s = div_trial_s[WIDTH:0];
        end else begin
            div_next_rem_s = {rem_r[WIDTH-1:0], opa_r[WIDTH-1]};
        end
        if (sign_a_r ^ sign_b_r) begin
            prod_fix_s = f_neg_wide(acc_r);
            quot_fix_s = f_neg(opa_r);
        end else begin
            prod_fix_s = acc_r;
            quot_fix_s = opa_r;
        end
        if (sign_a_r) begin
            rem_fix_s = f_neg(rem_r[WIDTH-1:0]);
        end else begin
            rem_fix_s = rem_r[WIDTH-1:0];
        end
`ifdef MULT_DIV_EARLY_EXIT_EN
        // True when the bit being consumed this cycle is the last possibly-set multiplier bit.
        mul_last_s = (opb_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`endif
    end

    // Sequencer FSM with registered status and HI/LO outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            op_r       <= 2'b00;
            opa_r      <= ZERO_W;
            opb_r      <= ZERO_W;
            mcand_r    <= ZERO_2W;
            acc_r      <= ZERO_2W;
            rem_r      <= {(WIDTH+1){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r       <= op;
                        opa_r      <= a;
                        opb_r      <= b;
                        div_zero_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_PREP;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_PREP: begin
                    sign_a_r <= is_signed_s & opa_r[WIDTH-1];
                    sign_b_r <= is_signed_s & opb_r[WIDTH-1];
                    opa_r    <= mag_a_s;
                    opb_r    <= mag_b_s;
                    mcand_r  <= {ZERO_W, mag_a_s};
                    acc_r    <= ZERO_2W;
                    rem_r    <= {(WIDTH+1){1'b0}};
                    cnt_r    <= CNT_W'(WIDTH);
                    if (is_div_s && (mag_b_s == ZERO_W)) begin
                        // Divide by zero: flag it and finish without touching HI/LO.
                        div_zero_r <= 1'b1;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= S_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (is_div_s) begin
                        rem_r <= div_next_rem_s;
                        opa_r <= {opa_r[WIDTH-2:0], div_ge_s};
                    end else begin
                        if (opb_r[0]) begin
                            acc_r <= mul_sum_s;
                        end else begin
                            acc_r <= acc_r;
                        end
                        mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
                        opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= S_FIX;
`ifdef MULT_DIV_EARLY_EXIT_EN
                    end else if (!is_div_s && mul_last_s) begin
                        // The accumulator is already aligned; skip the all-zero bits.
                        state_r <= S_FIX;
`endif
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_FIX: begin
                    if (is_div_s) begin
                        lo_r <= quot_fix_s;
                        hi_r <= rem_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    // A start seen here is dropped on purpose; the UC must re-issue from IDLE.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed cases plus randomized operations compared
// against a plain-arithmetic reference of HI/LO, div_zero and completion latency.
module tb_mult_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Issue one operation and follow it to completion, checking timing and results.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit repulse);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic [63:0] r64;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [31:0] mb;
        int          lat;
        int          obs;
        int          bad;
        int          n;
        int          bits;
        logic        dz1;

        prev_hi = exp_hi;
        prev_lo = exp_lo;
        lat     = 35;
        sx      = longint'($signed(x));
        sy      = longint'($signed(y));
        if (o[1] == 1'b0) begin
            if (o[0] == 1'b0) begin
                r64 = sx * sy;
            end else begin
                r64 = {32'h0, x} * {32'h0, y};
            end
            exp_hi = r64[63:32];
            exp_lo = r64[31:0];
            exp_dz = 1'b0;
`ifdef MULT_DIV_EARLY_EXIT_EN
            mb = (o[0] == 1'b0 && y[31]) ? (32'd0 - y) : y;
            bits = 0;
            for (int i = 0; i < 32; i++) begin
                if (mb[i]) bits = i + 1;
            end
            lat = ((bits == 0) ? 1 : bits) + 3;
`else
            mb = y;
            bits = 0;
`endif
        end else if (y == 32'h0) begin
            exp_dz = 1'b1;
            lat    = 2;
        end else begin
            exp_dz = 1'b0;
            if (o[0] == 1'b0) begin
                q = sx / sy;
                r = sx % sy;
                r64 = q;
                exp_lo = r64[31:0];
                r64 = r;
                exp_hi = r64[31:0];
            end else begin
                exp_lo = x / y;
                exp_hi = x % y;
            end
        end

        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        obs = 0; bad = 0; n = 1; dz1 = 1'b1;
        while (obs == 0 && n <= 60) begin
            start = 1'b0;
            if (n == 1) dz1 = div_zero;
            if (n == lat - 1) check_val("hold_hilo", {hi, lo}, {prev_hi, prev_lo});
            if (done) begin
                obs = n;
                if (busy) bad++;
                if (repulse) begin
                    start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
                end
            end else begin
                if (!busy) bad++;
                if (repulse && n == 10) begin
                    start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
                end
                @(negedge clk);
                n++;
            end
        end
        check_val("latency", 64'(obs), 64'(lat));
        check_val("busy_shape", 64'(bad), 64'd0);
        check_val("dz_cleared", {63'd0, dz1}, 64'd0);
        check_val("hi", {32'd0, hi}, {32'd0, exp_hi});
        check_val("lo", {32'd0, lo}, {32'd0, exp_lo});
        check_val("div_zero", {63'd0, div_zero}, {63'd0, exp_dz});
        @(negedge clk);
        start = 1'b0;
        check_val("idle_after", {62'd0, busy, done}, 64'd0);
    endtask

    // Abort a multiply with reset partway through RUN.
    task automatic reset_mid_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = 2'b00; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_hilo", {hi, lo}, 64'd0);
        check_val("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        checks = 0;
        errors = 0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = 32'h0;
        b      = 32'h0;
        repeat (3) @(negedge clk);
        check_val("reset_hilo", {hi, lo}, 64'd0);
        check_val("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b0;

        run_op(2'b01, 32'd7, 32'd6, 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op(2'b11, 32'hFFFFFFFF, 32'h10, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b01, 32'd9, 32'd3, 1'b0);
        run_op(2'b00, 32'd3, 32'h80000000, 1'b0);
        run_op(2'b00, 32'h12345678, 32'h9ABCDEF1, 1'b1);
        run_op(2'b10, 32'hDEADBEEF, 32'h00000123, 1'b1);
        run_op(2'b10, 32'd100, 32'd0, 1'b1);
        reset_mid_op(32'h0000FFFF, 32'hFFFF0001);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFFFFFF;
                1:       ry = $urandom >> $urandom_range(0, 31);
                2:       ry = 32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Iterative multiply/divide sequencer for the multicycle MIPS core. It executes mult, multu, div and divu one bit per cycle and holds the 64-bit result in HI/LO.
- The control unit (UC) launches an operation with a start pulse and stalls on busy.
- mfhi/mflo read the hi/lo outputs directly through the register-bank write-data mux.
- Operands come from the A and B registers.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  launch request from UC; sampled only in IDLE.
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start.
b  input  WIDTH  rt operand (multiplier / divisor); sampled with start.
busy  output  1  operation in progress; UC holds its current state while high.
done  output  1  one-cycle completion pulse.
div_zero  output  1  last division had divisor 0; sticky until the next accepted start.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - hi, lo, busy, done, div_zero go to 0.
  - Internal accumulators and the counter are cleared.
  - An operation in flight is discarded; no partial result reaches hi/lo.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1, latch op, a and b, clear div_zero, and go to PREP.
- PREP (1 cycle, busy=1):
  - Signed ops: record sign of a and sign of b; convert both operands to magnitudes.
  - Unsigned ops: operands pass through unchanged.
  - Load counter with WIDTH.
  - Division with b==0: set div_zero=1 and go directly to DONE; hi/lo unchanged.
  - Otherwise go to RUN.
- RUN (WIDTH cycles, busy=1):
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle; remainder is WIDTH+1 bits internally.
  - Counter decrements each cycle; at 1 go to FIX.
- FIX (1 cycle, busy=1):
  - Apply sign correction and write hi/lo.
  - Multiply: {hi,lo} = product; negated (two's complement, 2*WIDTH bits) when signed and signs differ.
  - Divide: lo = quotient, negated if signed and signs differ; hi = remainder, negated if signed and a was negative.
  - -2^31 / -1 wraps naturally: lo=0x80000000, hi=0. No trap, no flag.
  - Go to DONE.
- DONE (1 cycle):
  - busy=0, done=1.
  - hi/lo already hold the new values.
  - start in this cycle is ignored.
  - Go to IDLE.
- start is ignored in every state except IDLE; no queuing.
- Latency with start asserted in cycle k (baseline):
  - busy high in cycles k+1 .. k+WIDTH+2.
  - done high in cycle k+WIDTH+3 (cycle k+35 for WIDTH=32).
  - Division by zero: done in cycle k+2.
- hi/lo change only in FIX (or on reset); they are stable and readable at all other times.
- busy and done are never high in the same cycle.

Optional Feature:
Macro: MULT_DIV_EARLY_EXIT_EN
- Defined: in RUN for multiply ops, if the remaining unshifted multiplier bits are all zero, the accumulator is aligned in one step and the sequencer jumps to FIX. Results are identical; latency drops.
  - Example: multu 7*6 gives done at k+6.
  - Division is unchanged.
- Undefined: fixed latency for all ops as specified under Behaviour.

Test Plan:
- multu a=7, b=6 at cycle 0 → busy cycles 1..34; done at 35; hi=0x00000000, lo=0x0000002A.
- mult a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; divu 0xFFFFFFFF/0x10 → lo=0x0FFFFFFF, hi=0x0000000F.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000; then divu a=5, b=0 → done at cycle 2, div_zero=1, hi/lo keep the previous values, div_zero clears on the next accepted start.
- start re-pulsed with different operands during RUN and during DONE → ignored, original result delivered. reset asserted at cycle 10 of a mult → hi=lo=0, busy=0 immediately; a new start after reset release runs normally.
- With MULT_DIV_EARLY_EXIT_EN: multu 7*6 → done at cycle 6 with lo=0x2A; mult b=0x80000000 → full latency, correct result.
